// File: rtl/usart_tx_arbiter_pkg.sv
// Shared definitions for the USART transmit arbiter: FSM state encoding,
// default lock timeout and the pointer helper used by the top level.
package usart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_HANDOFF = 2'd2,
      ST_DRAIN   = 2'd3
   } arb_state_e;

   localparam int LOCK_TIMEOUT_DEF = 64;
   localparam int MAX_REQ          = 8;
   localparam int PTR_W            = 3;

   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/usart_tx_arbiter_rr_select.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, searching upward with wrap-around.
module usart_rr_select
   import usart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] winner_o,
   output logic               any_valid_o
);

   localparam int              SH_W = PTR_W + 1;
   localparam logic [SH_W-1:0] NREQ = SH_W'(NUM_REQ);

   logic [SH_W-1:0]    start;
   logic [NUM_REQ-1:0] rot;
   logic [NUM_REQ-1:0] pick;
   logic               found;

   // Rotate so the search start sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      start = {1'b0, ptr_i} + SH_W'(1);
      if (start >= NREQ) start = start - NREQ;
      rot   = NUM_REQ'({req_i, req_i} >> start);
      pick  = '0;
      found = 1'b0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (!found && rot[j]) begin
            pick[j] = 1'b1;
            found   = 1'b1;
         end
      end
      winner_o    = NUM_REQ'(({pick, pick} << start) >> NUM_REQ);
      any_valid_o = |req_i;
   end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Shares one usart_tx between NUM_REQ byte producers: round-robin per byte,
// with multi-byte frames locking the grant until their last byte.
module usart_tx_arbiter
   import usart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
   input  logic                 comm_clock,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_ready,
   input  logic                 tx_done
);

   localparam logic [7:0]       TIMEOUT = 8'(LOCK_TIMEOUT);
   localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(NUM_REQ - 1);

   arb_state_e         state_q, state_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [NUM_REQ-1:0] ready_q, ready_d;
   logic [NUM_REQ-1:0] lock_q, lock_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               last_q, last_d;
   logic               done_q, done_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [NUM_REQ-1:0] cand;
   logic [NUM_REQ-1:0] win_oh;
   logic               any_valid;
   logic [MAX_REQ-1:0] win_oh_ext;
   logic [7:0]         win_data;
   logic               win_last;

   // While a frame holds the lock only its owner competes.
   assign cand = (|lock_q) ? (req_valid & lock_q) : req_valid;

   usart_rr_select #(
      .NUM_REQ(NUM_REQ)
   ) u_rr_select (
      .req_i      (cand),
      .ptr_i      (ptr_q),
      .winner_o   (win_oh),
      .any_valid_o(any_valid)
   );

   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         win_data |= req_data[8*i +: 8] & {8{win_oh[i]}};
      end
      win_last                    = |(req_last & win_oh);
      win_oh_ext                  = '0;
      win_oh_ext[NUM_REQ-1:0]     = win_oh;
   end

   always_ff @(posedge comm_clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         tx_data_q <= '0;
         grant_q   <= '0;
         ready_q   <= '0;
         lock_q    <= '0;
         ptr_q     <= PTR_RST;
         last_q    <= 1'b0;
         done_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         tx_data_q <= tx_data_d;
         grant_q   <= grant_d;
         ready_q   <= ready_d;
         lock_q    <= lock_d;
         ptr_q     <= ptr_d;
         last_q    <= last_d;
         done_q    <= done_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      grant_d   = grant_q;
      ready_d   = '0;
      lock_d    = lock_q;
      ptr_d     = ptr_q;
      last_d    = last_q;
      done_d    = done_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid) begin
               tx_data_d = win_data;
               ready_d   = win_oh;
               grant_d   = win_oh;
               ptr_d     = onehot_to_idx(win_oh_ext);
               last_d    = win_last;
               cnt_d     = '0;
               state_d   = ST_LOAD;
            end else if (|lock_q) begin
               // Idle owner: release the lock once it has been quiet long enough.
               if (cnt_q + 8'd1 == TIMEOUT) begin
                  lock_d = '0;
                  cnt_d  = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_LOAD: begin
            if (tx_done) done_d = 1'b1;
            if (tx_ready) state_d = ST_HANDOFF;
         end
         ST_HANDOFF: begin
            if (tx_done) done_d = 1'b1;
            if (!tx_ready) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (tx_done || done_q) begin
               state_d = ST_IDLE;
               grant_d = '0;
               lock_d  = last_q ? '0 : grant_q;
               cnt_d   = '0;
               done_d  = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_valid  = (state_q == ST_LOAD);
      busy      = (state_q != ST_IDLE);
      req_ready = ready_q;
      grant     = grant_q;
      tx_data   = tx_data_q;
   end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Self-checking bench for usart_tx_arbiter with a behavioural usart_tx model
// and a queue-level arbitration reference.
module tb_usart_tx_arbiter;

   localparam int N  = 2;
   localparam int TO = 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [8*N-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     grant;
   logic             busy;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   usart_tx_arbiter #(
      .NUM_REQ     (N),
      .LOCK_TIMEOUT(TO)
   ) dut (
      .comm_clock(clk),
      .reset     (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .grant     (grant),
      .busy      (busy),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_done   (tx_done)
   );

   // usart_tx model: latches a byte, holds tx_ready two cycles, then pulses tx_done
   bit           model_en   = 1'b1;
   bit           early_next = 1'b0;
   bit           rand_early = 1'b0;
   logic [7:0]   wire_q[$];
   logic [N-1:0] gnt_q[$];

   initial begin
      bit early;
      int gap;
      tx_ready = 1'b0;
      tx_done  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (model_en && tx_valid) begin
            early = early_next || (rand_early && ($urandom_range(0, 3) == 0));
            gap   = $urandom_range(1, 4);
            wire_q.push_back(tx_data);
            gnt_q.push_back(grant);
            tx_ready = 1'b1;
            @(posedge clk);
            #1;
            if (early) tx_done = 1'b1;
            @(posedge clk);
            #1;
            tx_ready = 1'b0;
            tx_done  = 1'b0;
            if (!early) begin
               repeat (gap) @(posedge clk);
               #1;
               tx_done = 1'b1;
               @(posedge clk);
               #1;
               tx_done = 1'b0;
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(busy), 32'd0);
   endtask

   // Per-requester byte queues: {last, data}
   logic [8:0] rq[N][$];
   logic [8:0] mq[N][$];
   logic [7:0] exp_d[$];
   logic [N-1:0] exp_g[$];

   // Reference: round-robin over non-empty queues, frame owner keeps the grant.
   task automatic predict();
      int lockw;
      int p;
      int w;
      int c;
      logic [8:0] e;
      logic [N-1:0] g;
      lockw = -1;
      p     = N - 1;
      exp_d.delete();
      exp_g.delete();
      for (int i = 0; i < N; i++) mq[i] = rq[i];
      forever begin
         w = -1;
         if (lockw >= 0) w = lockw;
         else begin
            for (int k = 1; k <= N; k++) begin
               c = (p + k) % N;
               if (w < 0 && mq[c].size() > 0) w = c;
            end
         end
         if (w < 0) break;
         e = mq[w].pop_front();
         g = '0;
         g[w] = 1'b1;
         exp_d.push_back(e[7:0]);
         exp_g.push_back(g);
         p     = w;
         lockw = e[8] ? -1 : w;
      end
   endtask

   task automatic run_queues(input int nbytes);
      int cyc;
      cyc = 0;
      wire_q.delete();
      gnt_q.delete();
      while ((wire_q.size() < nbytes || busy) && cyc < nbytes * 40 + 200) begin
         for (int i = 0; i < N; i++) begin
            if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            req_valid[i]        = (rq[i].size() > 0);
            req_data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
            req_last[i]         = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = '0;
      check("queue_byte_count", 32'(wire_q.size()), 32'(nbytes));
   endtask

   typedef struct packed {
      logic [1:0] valid;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] last;
      logic [1:0] exp_gnt;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vt[5];

   initial begin
      int n;
      int total;
      int nf;
      int len;

      vt[0] = '{2'b01, 8'h41, 8'h00, 2'b11, 2'b01, 8'h41};
      vt[1] = '{2'b10, 8'h00, 8'h5A, 2'b11, 2'b10, 8'h5A};
      vt[2] = '{2'b01, 8'hC3, 8'h00, 2'b11, 2'b01, 8'hC3};
      vt[3] = '{2'b11, 8'h3C, 8'h99, 2'b11, 2'b01, 8'h3C};
      vt[4] = '{2'b11, 8'h00, 8'hFF, 2'b00, 2'b01, 8'h00};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_tx_data", 32'(tx_data), 32'd0);

      // First-grant table, each vector from a fresh reset
      for (int i = 0; i < 5; i++) begin
         do_reset();
         req_valid = vt[i].valid;
         req_data  = {vt[i].d1, vt[i].d0};
         req_last  = vt[i].last;
         @(negedge clk);
         check("vec_ready", 32'(req_ready), 32'(vt[i].exp_gnt));
         check("vec_grant", 32'(grant), 32'(vt[i].exp_gnt));
         check("vec_tx_data", 32'(tx_data), 32'(vt[i].exp_data));
         check("vec_tx_valid", 32'(tx_valid), 32'd1);
         req_valid = '0;
         wait_idle("vec_idle");
      end

      // Single byte: pulse width, tx_valid drop, busy falling after tx_done
      do_reset();
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h41};
      req_last  = 2'b11;
      @(negedge clk);
      check("single_ready", 32'(req_ready), 32'h1);
      check("single_tx_data", 32'(tx_data), 32'h41);
      req_valid = '0;
      @(negedge clk);
      check("single_ready_pulse", 32'(req_ready), 32'h0);
      check("single_tx_valid_drop", 32'(tx_valid), 32'h0);
      n = 0;
      while (!tx_done && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("single_done_seen", 32'(tx_done), 32'h1);
      check("single_busy_at_done", 32'(busy), 32'h1);
      check("single_grant_at_done", 32'(grant), 32'h1);
      @(negedge clk);
      check("single_busy_after", 32'(busy), 32'h0);
      check("single_grant_after", 32'(grant), 32'h0);

      // Contention: held streams alternate starting with requester 0
      do_reset();
      wire_q.delete();
      gnt_q.delete();
      req_valid = 2'b11;
      req_data  = {8'hB0, 8'hA0};
      req_last  = 2'b11;
      n = 0;
      while (wire_q.size() < 4 && n < 400) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      wait_idle("contend_idle");
      check("contend_count", 32'(wire_q.size()), 32'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < wire_q.size()) begin
            check("contend_data", 32'(wire_q[k]), (k % 2 == 0) ? 32'hA0 : 32'hB0);
            check("contend_grant", 32'(gnt_q[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
         end
      end

      // Frame lock: 10,11,12 from req0 before req1's FF
      do_reset();
      rq[0].push_back({1'b0, 8'h10});
      rq[0].push_back({1'b0, 8'h11});
      rq[0].push_back({1'b1, 8'h12});
      rq[1].push_back({1'b1, 8'hFF});
      run_queues(4);
      for (int k = 0; k < 4; k++) begin
         if (k < wire_q.size()) begin
            check("lock_data", 32'(wire_q[k]), (k == 3) ? 32'hFF : 32'h10 + 32'(k));
            check("lock_grant", 32'(gnt_q[k]), (k == 3) ? 32'h2 : 32'h1);
         end
      end

      // Lock timeout: req1 waits out the idle lock of req0
      do_reset();
      req_valid = 2'b11;
      req_data  = {8'h77, 8'h55};
      req_last  = 2'b10;
      @(negedge clk);
      check("to_first_ready", 32'(req_ready), 32'h1);
      req_valid = 2'b10;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("to_busy_fell", 32'(busy), 32'h0);
      n = 0;
      while (!req_ready[1] && n < 300) begin
         @(negedge clk);
         n++;
      end
      // TO idle cycles reach the limit, the next cycle arbitrates, ready shows one later
      check("to_gap", 32'(n), 32'(TO + 1));
      req_valid = '0;
      wait_idle("to_idle");

      // Early tx_done during HANDOFF is latched
      do_reset();
      wire_q.delete();
      early_next = 1'b1;
      req_valid  = 2'b01;
      req_data   = {8'h00, 8'h66};
      req_last   = 2'b01;
      @(negedge clk);
      req_valid = '0;
      wait_idle("early_idle");
      early_next = 1'b0;
      repeat (10) @(negedge clk);
      check("early_count", 32'(wire_q.size()), 32'd1);
      check("early_busy", 32'(busy), 32'h0);

      // Reset mid-LOAD clears the frame lock held by requester 0
      do_reset();
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h20};
      req_last  = 2'b00;
      @(negedge clk);
      req_valid = '0;
      wait_idle("rstld_first_idle");
      model_en  = 1'b0;
      req_valid = 2'b01;
      req_data  = {8'h00, 8'h21};
      @(negedge clk);
      check("rstld_tx_valid", 32'(tx_valid), 32'h1);
      req_valid = '0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstld_tx_valid_clr", 32'(tx_valid), 32'h0);
      check("rstld_grant", 32'(grant), 32'h0);
      check("rstld_busy", 32'(busy), 32'h0);
      model_en  = 1'b1;
      req_valid = 2'b10;
      req_data  = {8'h31, 8'h00};
      req_last  = 2'b11;
      @(negedge clk);
      check("rstld_unlocked", 32'(req_ready), 32'h2);
      req_valid = '0;
      wait_idle("rstld_idle");

      // Randomised frames against the queue-level reference
      rand_early = 1'b1;
      for (int r = 0; r < 6; r++) begin
         do_reset();
         total = 0;
         for (int i = 0; i < N; i++) begin
            rq[i].delete();
            nf = $urandom_range((i == 0) ? 1 : 0, 3);
            for (int f = 0; f < nf; f++) begin
               len = $urandom_range(1, 3);
               for (int b = 0; b < len; b++) begin
                  rq[i].push_back({(b == len - 1), 8'($urandom)});
                  total++;
               end
            end
         end
         predict();
         run_queues(total);
         for (int k = 0; k < total; k++) begin
            if (k < wire_q.size()) begin
               check("rand_data", 32'(wire_q[k]), 32'(exp_d[k]));
               check("rand_grant", 32'(gnt_q[k]), 32'(exp_g[k]));
            end
         end
      end
      rand_early = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
